// File: rtl/tile_bus_arb.sv
// tile_bus_arb: arbiter and 16-word burst sequencer for the external memory bus.
// Optional TILEARB_RR_EN selects round-robin tie-break; default is fixed D priority.
module tile_bus_arb #(
  parameter int BURST_LEN  = 16,
  parameter int TILE_SHIFT = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         iReq,
  input  logic [47:0]                  iAddr,
  output logic                         iDone,
  input  logic                         dReq,
  input  logic                         dWb,
  input  logic [47:0]                  dWbAddr,
  input  logic [47:0]                  dLdAddr,
  input  logic [31:0]                  dWrData,
  output logic                         dDone,
  output logic [$clog2(BURST_LEN)-1:0] wIdx,
  output logic                         wStb,
  output logic                         wIsI,
  output logic [31:0]                  rdData,
  output logic [47:0]                  extAddr,
  output logic [31:0]                  extDataOut,
  input  logic [31:0]                  extDataIn,
  output logic                         extOE,
  output logic                         extWR,
  output logic                         extHold,
  input  logic                         extNotReady
);

  localparam int IW = $clog2(BURST_LEN);
  localparam logic [IW-1:0] LAST = IW'(BURST_LEN - 1);
  localparam logic [47:0] MASK = ~((48'd1 << TILE_SHIFT) - 48'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_XFER,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_nstate;

  logic [47:0]     r_base;
  logic [47:0]     r_ld;
  logic            r_gntI;
  logic            r_st;
  logic [IW-1:0]   r_wIdx;
  logic            r_oe;
  logic            r_wr;
  logic            r_iDone;
  logic            r_dDone;

  logic [47:0]     w_base;
  logic [47:0]     w_ld;
  logic            w_gntI;
  logic            w_st;
  logic [IW-1:0]   w_wIdx;
  logic            w_oe;
  logic            w_wr;
  logic            w_iDone;
  logic            w_dDone;

  logic            w_go;
  logic            w_tieI;
  logic            w_pickI;
  logic            w_grantSt;
  logic            w_lastWord;

`ifdef TILEARB_RR_EN
  logic            r_lastI;

  // round-robin pointer: remembers who was served last, updated in DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lastI <= 1'b1;
    end else if (r_state == S_DONE) begin
      r_lastI <= r_gntI;
    end
  end

  assign w_tieI = ~r_lastI;
`else
  assign w_tieI = 1'b0;
`endif

  assign w_go       = iReq | dReq;
  assign w_pickI    = iReq & (~dReq | w_tieI);
  assign w_grantSt  = ~w_pickI & dWb;
  assign w_lastWord = ~extNotReady & (r_wIdx == LAST);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  // next-state logic
  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE: if (w_go) w_nstate = S_ADDR;
      S_ADDR: w_nstate = S_XFER;
      S_XFER: begin
        if (w_lastWord) begin
          w_nstate = r_st ? S_ADDR : S_DONE;
        end
      end
      S_DONE: w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // next values of the registered outputs and transaction latches
  always_comb begin
    w_base  = r_base;
    w_ld    = r_ld;
    w_gntI  = r_gntI;
    w_st    = r_st;
    w_wIdx  = r_wIdx;
    w_oe    = r_oe;
    w_wr    = r_wr;
    w_iDone = 1'b0;
    w_dDone = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_gntI = w_pickI;
          w_st   = w_grantSt;
          w_ld   = dLdAddr & MASK;
          w_wIdx = '0;
          w_oe   = ~w_grantSt;
          w_wr   = w_grantSt;
          if (w_pickI) begin
            w_base = iAddr & MASK;
          end else if (dWb) begin
            w_base = dWbAddr & MASK;
          end else begin
            w_base = dLdAddr & MASK;
          end
        end
      end
      S_ADDR: begin
        w_wIdx = '0;
      end
      S_XFER: begin
        if (w_lastWord) begin
          if (r_st) begin
            w_st   = 1'b0;
            w_base = r_ld;
            w_wIdx = '0;
            w_wr   = 1'b0;
            w_oe   = 1'b1;
          end else begin
            w_oe    = 1'b0;
            w_wr    = 1'b0;
            w_iDone = r_gntI;
            w_dDone = ~r_gntI;
          end
        end else if (!extNotReady) begin
          w_wIdx = r_wIdx + 1'b1;
        end
      end
      S_DONE: begin
        w_wIdx = '0;
        w_oe   = 1'b0;
        w_wr   = 1'b0;
      end
      default: begin
        w_oe = 1'b0;
        w_wr = 1'b0;
      end
    endcase
  end

  // output and latch registers; reset drops any burst in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_base  <= '0;
      r_ld    <= '0;
      r_gntI  <= 1'b0;
      r_st    <= 1'b0;
      r_wIdx  <= '0;
      r_oe    <= 1'b0;
      r_wr    <= 1'b0;
      r_iDone <= 1'b0;
      r_dDone <= 1'b0;
    end else begin
      r_base  <= w_base;
      r_ld    <= w_ld;
      r_gntI  <= w_gntI;
      r_st    <= w_st;
      r_wIdx  <= w_wIdx;
      r_oe    <= w_oe;
      r_wr    <= w_wr;
      r_iDone <= w_iDone;
      r_dDone <= w_dDone;
    end
  end

  assign wIdx       = r_wIdx;
  assign wStb       = (r_state == S_XFER) & ~extNotReady;
  assign wIsI       = r_gntI;
  assign extOE      = r_oe;
  assign extWR      = r_wr;
  assign extHold    = (r_state != S_IDLE);
  assign iDone      = r_iDone;
  assign dDone      = r_dDone;
  assign extAddr    = r_base | {{(48-IW-2){1'b0}}, r_wIdx, 2'b00};
  assign rdData     = r_oe ? extDataIn : 32'd0;
  assign extDataOut = r_wr ? dWrData : 32'd0;

endmodule
